// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch unit: issues one memory request at a time,
// holds the fetched word for the decoder, and handles redirects, halts and misaligned targets.
module inst_fetch #(
    parameter int unsigned     XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;
    logic            drop_q, drop_d;
    logic            halt_pend_q, halt_pend_d;
    logic            fetch_err_q, fetch_err_d;

    logic            bad_redir;
    logic            good_redir;
    logic            stop;
    logic [XLEN-1:0] pc_tgt;

    always_comb begin
        bad_redir  = redirect_valid && (redirect_pc[1:0] != 2'b00);
        good_redir = redirect_valid && !bad_redir;
        // A halt or misaligned redirect seen this cycle counts immediately.
        stop       = halt_pend_q || halt || bad_redir;
        pc_tgt     = good_redir ? redirect_pc : pc_q;

        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        inst_d      = inst_q;
        inst_pc_d   = inst_pc_q;
        drop_d      = drop_q;
        halt_pend_d = halt_pend_q;
        fetch_err_d = fetch_err_q;

        if (state_q != S_HALTED) begin
            halt_pend_d = stop;
            fetch_err_d = fetch_err_q || bad_redir;
        end

        case (state_q)
            S_IDLE: begin
                pc_d       = pc_tgt;
                req_addr_d = pc_tgt;
                state_d    = stop ? S_HALTED : S_REQ;
            end
            S_REQ: begin
                pc_d = pc_tgt;
                if (good_redir) drop_d = 1'b1;
                if (imem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                pc_d = pc_tgt;
                if (good_redir) drop_d = 1'b1;
                if (imem_rsp_valid) begin
                    if (!drop_q && !redirect_valid) begin
                        if (stop) begin
                            state_d = S_HALTED;
                        end else begin
                            inst_d    = imem_rsp_data;
                            inst_pc_d = req_addr_q;
                            pc_d      = req_addr_q + XLEN'(4);
                            state_d   = S_HOLD;
                        end
                    end else begin
                        drop_d     = 1'b0;
                        req_addr_d = pc_tgt;
                        state_d    = stop ? S_HALTED : S_REQ;
                    end
                end
            end
            S_HOLD: begin
                // Consumption and a bare redirect both release the held word.
                if (inst_ready || redirect_valid) begin
                    pc_d       = pc_tgt;
                    req_addr_d = pc_tgt;
                    state_d    = stop ? S_HALTED : S_REQ;
                end
            end
            default: state_d = S_HALTED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            inst_q      <= '0;
            inst_pc_q   <= '0;
            drop_q      <= 1'b0;
            halt_pend_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            inst_q      <= inst_d;
            inst_pc_q   <= inst_pc_d;
            drop_q      <= drop_d;
            halt_pend_q <= halt_pend_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    always_comb begin
        imem_req_valid = (state_q == S_REQ);
        imem_req_addr  = (state_q == S_HALTED) ? '0 : req_addr_q;
        inst_valid     = (state_q == S_HOLD);
        inst           = (state_q == S_HALTED) ? '0 : inst_q;
        inst_pc        = inst_pc_q;
        fetch_err      = fetch_err_q;
    end

endmodule
